// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: decodes SPI slave command words into accesses on a
// single-port RAM and shares that port with a local host (BIST/debug) port.
// The SPI side cannot be stalled, so its requests sit in a one-entry pending
// buffer and always win arbitration over the host.
module spi_ram_arbiter #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // SPI slave side
  input  logic [9:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  // Host side
  input  logic                 host_req,
  input  logic                 host_we,
  input  logic [ADDR_SIZE-1:0] host_addr,
  input  logic [7:0]           host_wdata,
  output logic                 host_gnt,
  output logic [7:0]           host_rdata,
  output logic                 host_rvalid,
  // RAM side
  output logic                 ram_en,
  output logic                 ram_we,
  output logic [ADDR_SIZE-1:0] ram_addr,
  output logic [7:0]           ram_wdata,
  input  logic [7:0]           ram_rdata,
  // Status
  output logic                 err_ovf
);

  // The address is taken from the low bits of an 8-bit payload, and the RAM
  // must fit inside that address space.
  if (ADDR_SIZE > 8 || MEM_DEPTH > (1 << ADDR_SIZE)) begin : g_param_err
    $error("spi_ram_arbiter: ADDR_SIZE must be <= 8 and MEM_DEPTH <= 2**ADDR_SIZE");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // SPI command codes in rx_data[9:8]
  localparam logic [1:0] CMD_SET_WADDR = 2'b00;
  localparam logic [1:0] CMD_WRITE     = 2'b01;
  localparam logic [1:0] CMD_SET_RADDR = 2'b10;
  localparam logic [1:0] CMD_READ      = 2'b11;

  state_e state_q, state_d;

  logic [ADDR_SIZE-1:0] wr_addr_q, rd_addr_q;

  // One-entry pending buffer for SPI accesses
  logic                 pend_valid_q;
  logic                 pend_we_q;
  logic [ADDR_SIZE-1:0] pend_addr_q;
  logic [7:0]           pend_wdata_q;

  // Request latched at the IDLE->ACC transition
  logic                 req_we_q;
  logic [ADDR_SIZE-1:0] req_addr_q;
  logic [7:0]           req_wdata_q;
  logic                 owner_host_q;

  logic [7:0]           tx_data_q, host_rdata_q;
  logic                 tx_valid_q, host_rvalid_q, err_ovf_q;

  logic [1:0]           cmd;
  logic [ADDR_SIZE-1:0] payload_addr;
  logic                 capture, consume, load_spi, load_host;

  assign cmd          = rx_data[9:8];
  assign payload_addr = rx_data[ADDR_SIZE-1:0];
  // Commands 01 and 11 are the ones that queue a RAM access.
  assign capture      = rx_valid && cmd[0];
  assign consume      = (state_q == S_IDLE) && pend_valid_q;

  // Address registers written by the 00/10 commands.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else if (rx_valid) begin
      if (cmd == CMD_SET_WADDR) wr_addr_q <= payload_addr;
      if (cmd == CMD_SET_RADDR) rd_addr_q <= payload_addr;
    end
  end

  // Pending buffer: a capture in the consuming cycle refills it (set wins),
  // a capture into a full, unconsumed buffer is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid_q <= 1'b0;
      pend_we_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_wdata_q <= '0;
      err_ovf_q    <= 1'b0;
    end else begin
      if (capture && (!pend_valid_q || consume)) begin
        pend_valid_q <= 1'b1;
        pend_we_q    <= (cmd == CMD_WRITE);
        pend_addr_q  <= (cmd == CMD_READ) ? rd_addr_q : wr_addr_q;
        pend_wdata_q <= (cmd == CMD_WRITE) ? rx_data[7:0] : 8'h00;
      end else if (consume) begin
        pend_valid_q <= 1'b0;
      end
      if (capture && pend_valid_q && !consume) err_ovf_q <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state: SPI pending has fixed priority over the host.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    load_spi  = 1'b0;
    load_host = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pend_valid_q) begin
          load_spi = 1'b1;
          state_d  = S_ACC;
        end else if (host_req) begin
          load_host = 1'b1;
          state_d   = S_ACC;
        end
      end
      S_ACC:   state_d = req_we_q ? S_IDLE : S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the winning request when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      owner_host_q <= 1'b0;
    end else if (load_spi) begin
      req_we_q     <= pend_we_q;
      req_addr_q   <= pend_addr_q;
      req_wdata_q  <= pend_wdata_q;
      owner_host_q <= 1'b0;
    end else if (load_host) begin
      req_we_q     <= host_we;
      req_addr_q   <= host_addr;
      req_wdata_q  <= host_wdata;
      owner_host_q <= 1'b1;
    end
  end

  // Register read data in RESP and pulse the owner's valid on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      tx_valid_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      if (state_q == S_RESP) begin
        if (owner_host_q) begin
          host_rdata_q  <= ram_rdata;
          host_rvalid_q <= 1'b1;
        end else begin
          tx_data_q  <= ram_rdata;
          tx_valid_q <= 1'b1;
        end
      end
    end
  end

  // RAM port is only driven during ACC; the host grant coincides with it.
  assign ram_en      = (state_q == S_ACC);
  assign ram_we      = ram_en && req_we_q;
  assign ram_addr    = req_addr_q;
  assign ram_wdata   = req_wdata_q;
  assign host_gnt    = ram_en && owner_host_q;

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign err_ovf     = err_ovf_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Directed testbench for spi_ram_arbiter with a behavioural single-port RAM.
module tb_spi_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       host_req = 1'b0;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata;
  logic [7:0] ram_rdata;
  logic       err_ovf;

  int checks = 0;
  int failures = 0;

  spi_ram_arbiter #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous RAM: read data appears the cycle after the access.
  // NOTE: the RAM array has no reset; contents survive rst_n like a real macro.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one SPI word for one cycle; returns in the cycle after rx_valid.
  task automatic spi_cmd(input logic [9:0] word);
    rx_data  = word;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({tx_valid, host_gnt, host_rvalid, ram_en, ram_we, err_ovf} !== 6'b0) begin
      failures++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {tx_valid, host_gnt, host_rvalid, ram_en, ram_we, err_ovf});
    end
    checks++;
    if ({tx_data, host_rdata, ram_addr, ram_wdata} !== 32'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 00000000",
               {tx_data, host_rdata, ram_addr, ram_wdata});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_spi_write();
    int tx_seen = 0;
    spi_cmd(10'h012);
    repeat (11) tick();
    spi_cmd(10'h1AB);                 // now in cycle N+1
    checks++;
    if (ram_en !== 1'b0) begin
      failures++;
      $display("FAIL wr_early_en: got %b expected 0", ram_en);
    end
    tick();                           // cycle N+2
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h12, 8'hAB}) begin
      failures++;
      $display("FAIL wr_access: got en=%b we=%b addr=%h wdata=%h expected 1 1 12 ab",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (tx_valid === 1'b1) tx_seen++;
    end
    checks++;
    if (tx_seen !== 0) begin
      failures++;
      $display("FAIL wr_no_tx: got %0d tx_valid pulses expected 0", tx_seen);
    end
  endtask

  task automatic test_spi_read();
    spi_cmd(10'h212);
    repeat (11) tick();
    spi_cmd(10'h300);                 // cycle N+1
    tick();                           // N+2
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 8'h12}) begin
      failures++;
      $display("FAIL rd_access: got en=%b we=%b addr=%h expected 1 0 12",
               ram_en, ram_we, ram_addr);
    end
    tick();                           // N+3
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_early_tx: got %b expected 0", tx_valid);
    end
    tick();                           // N+4
    checks++;
    if ({tx_valid, tx_data, host_rvalid} !== {1'b1, 8'hAB, 1'b0}) begin
      failures++;
      $display("FAIL rd_tx: got valid=%b data=%h hrv=%b expected 1 ab 0",
               tx_valid, tx_data, host_rvalid);
    end
    tick();                           // N+5
    checks++;
    if ({tx_valid, tx_data} !== {1'b0, 8'hAB}) begin
      failures++;
      $display("FAIL rd_tx_hold: got valid=%b data=%h expected 0 ab", tx_valid, tx_data);
    end
  endtask

  // Host read with a bounded wait for the grant; checks the 2-cycle response.
  task automatic host_read(input logic [7:0] addr, input logic [7:0] exp, input string name);
    int budget = 20;
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = addr;
    while (host_gnt !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    host_req = 1'b0;
    checks++;
    if (budget == 0) begin
      failures++;
      $display("FAIL %s_gnt_timeout: got no host_gnt expected one within 20 cycles", name);
    end else begin
      tick();
      tick();
      checks++;
      if ({host_rvalid, host_rdata, tx_valid} !== {1'b1, exp, 1'b0}) begin
        failures++;
        $display("FAIL %s_rdata: got rvalid=%b data=%h tx_valid=%b expected 1 %h 0",
                 name, host_rvalid, host_rdata, tx_valid, exp);
      end
    end
    tick();
  endtask

  task automatic test_contention();
    repeat (10) tick();
    spi_cmd(10'h155);                 // N+1: pending set, host arrives
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = 8'h40;
    host_wdata = 8'h5A;
    checks++;
    if (host_gnt !== 1'b0) begin
      failures++;
      $display("FAIL cont_gnt_early: got %b expected 0", host_gnt);
    end
    tick();                           // N+2: SPI write wins
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, host_gnt} !== {1'b1, 1'b1, 8'h12, 8'h55, 1'b0}) begin
      failures++;
      $display("FAIL cont_spi_first: got en=%b we=%b addr=%h wdata=%h gnt=%b expected 1 1 12 55 0",
               ram_en, ram_we, ram_addr, ram_wdata, host_gnt);
    end
    tick();                           // N+3: IDLE
    checks++;
    if ({ram_en, host_gnt} !== 2'b00) begin
      failures++;
      $display("FAIL cont_idle_gap: got en=%b gnt=%b expected 0 0", ram_en, host_gnt);
    end
    tick();                           // N+4: host write
    checks++;
    if ({host_gnt, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h40, 8'h5A}) begin
      failures++;
      $display("FAIL cont_host_wr: got gnt=%b we=%b addr=%h wdata=%h expected 1 1 40 5a",
               host_gnt, ram_we, ram_addr, ram_wdata);
    end
    host_req = 1'b0;
    tick();
    host_read(8'h40, 8'h5A, "cont_readback");
  endtask

  task automatic test_overflow();
    int extra_en = 0;
    spi_cmd(10'h020);                 // wr_addr = 0x20
    repeat (4) tick();
    host_req  = 1'b1;                 // cycle H, FSM idle
    host_we   = 1'b0;
    host_addr = 8'h40;
    tick();                           // H+1: host ACC
    checks++;
    if (host_gnt !== 1'b1) begin
      failures++;
      $display("FAIL ovf_host_gnt: got %b expected 1", host_gnt);
    end
    host_req = 1'b0;
    rx_data  = 10'h111;
    rx_valid = 1'b1;
    tick();                           // H+2: RESP, pending full
    rx_data  = 10'h122;
    tick();                           // H+3: second command dropped
    rx_valid = 1'b0;
    checks++;
    if ({err_ovf, host_rvalid, host_rdata} !== {1'b1, 1'b1, 8'h5A}) begin
      failures++;
      $display("FAIL ovf_flag: got ovf=%b rvalid=%b rdata=%h expected 1 1 5a",
               err_ovf, host_rvalid, host_rdata);
    end
    tick();                           // H+4: first command written
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h20, 8'h11}) begin
      failures++;
      $display("FAIL ovf_first_wr: got en=%b we=%b addr=%h wdata=%h expected 1 1 20 11",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ram_en === 1'b1) extra_en++;
    end
    checks++;
    if (extra_en !== 0) begin
      failures++;
      $display("FAIL ovf_second_dropped: got %0d extra accesses expected 0", extra_en);
    end
    host_read(8'h20, 8'h11, "ovf_readback");
    checks++;
    if (err_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: got %b expected 1", err_ovf);
    end
  endtask

  task automatic test_addr_snapshot();
    repeat (8) tick();
    spi_cmd(10'h003);
    repeat (11) tick();
    spi_cmd(10'h1CC);                 // N+1
    spi_cmd(10'h007);                 // rx_valid in N+1, now N+2
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 8'h03, 8'hCC}) begin
      failures++;
      $display("FAIL snap_wr: got en=%b we=%b addr=%h wdata=%h expected 1 1 03 cc",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    repeat (3) tick();
    host_read(8'h03, 8'hCC, "snap_readback");
  endtask

  task automatic test_reset_mid_read();
    int tx_seen = 0;
    spi_cmd(10'h000);                 // wr_addr = 0
    repeat (11) tick();
    spi_cmd(10'h177);                 // RAM[0] = 0x77
    repeat (11) tick();
    spi_cmd(10'h203);                 // rd_addr = 3
    repeat (11) tick();
    spi_cmd(10'h300);                 // N+1
    tick();                           // N+2 ACC
    tick();                           // N+3 RESP
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_valid, ram_en, err_ovf} !== 3'b000) begin
      failures++;
      $display("FAIL rst_mid_read: got tx_valid=%b ram_en=%b err_ovf=%b expected 0 0 0",
               tx_valid, ram_en, err_ovf);
    end
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (tx_valid === 1'b1) tx_seen++;
    end
    checks++;
    if (tx_seen !== 0) begin
      failures++;
      $display("FAIL rst_no_tx: got %0d tx_valid pulses expected 0", tx_seen);
    end
    spi_cmd(10'h300);                 // rd_addr cleared to 0 by reset
    tick(); tick(); tick();           // N+4
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h77}) begin
      failures++;
      $display("FAIL rst_read0: got valid=%b data=%h expected 1 77", tx_valid, tx_data);
    end
  endtask

  initial begin
    test_reset();
    test_spi_write();
    test_spi_read();
    test_contention();
    test_overflow();
    test_addr_snapshot();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time bound");
    $fatal(1, "watchdog expired");
  end

endmodule
